// File: rtl/link_input_stage_pkg.sv
// Shared constants and types for the link input stage: flit width, pad value,
// direction indices and the four-lane flit array type.
package link_input_stage_pkg;

    localparam int FLIT_W   = 10;
    localparam int NUM_DIRS = 4;

    localparam logic [FLIT_W-1:0] NULL_FLIT = 10'h000;

    localparam int DIR_N = 0;
    localparam int DIR_S = 1;
    localparam int DIR_E = 2;
    localparam int DIR_W = 3;

    typedef logic [NUM_DIRS-1:0][FLIT_W-1:0] quad_t;

endpackage

// File: rtl/link_input_stage_if.sv
// Link-side and quad-side handshake bundle of the link input stage.
// stall_cnt exists only when STALL_CNT_EN is defined.
interface link_input_stage_if;
    import link_input_stage_pkg::*;

    logic [FLIT_W-1:0] n_flit, s_flit, e_flit, w_flit;
    logic              n_valid, s_valid, e_valid, w_valid;
    logic              n_ready, s_ready, e_ready, w_ready;
    logic [FLIT_W-1:0] nty, sty, ety, wty;
    logic [3:0]        dir_vld;
    logic              out_valid;
    logic              out_ready;
`ifdef STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    modport master (
        output n_flit, s_flit, e_flit, w_flit,
        output n_valid, s_valid, e_valid, w_valid,
        input  n_ready, s_ready, e_ready, w_ready,
        input  nty, sty, ety, wty, dir_vld, out_valid,
`ifdef STALL_CNT_EN
        input  stall_cnt,
`endif
        output out_ready
    );

    modport slave (
        input  n_flit, s_flit, e_flit, w_flit,
        input  n_valid, s_valid, e_valid, w_valid,
        output n_ready, s_ready, e_ready, w_ready,
        output nty, sty, ety, wty, dir_vld, out_valid,
`ifdef STALL_CNT_EN
        output stall_cnt,
`endif
        input  out_ready
    );

endinterface

// File: rtl/link_input_stage_flit_fifo.sv
// Per-direction flit FIFO. Head is read combinationally from storage, so a push
// into an empty FIFO only becomes poppable on the following edge.
module flit_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic                        push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/link_input_stage.sv
// Buffers N/S/E/W link flits per direction and emits aligned quads through one
// output register. Optional stall counter enabled by STALL_CNT_EN.
import link_input_stage_pkg::*;

module link_input_stage #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    link_input_stage_if.slave  bus
);

    quad_t                          in_flit, fifo_dout, out_q;
    logic [NUM_DIRS-1:0]            in_vld, rdy, push, pop, full, empty;
    logic [NUM_DIRS-1:0][CNT_W-1:0] cnt;
    logic [NUM_DIRS-1:0]            dir_vld;
    logic                           out_valid, load;

    assign in_flit[DIR_N] = bus.n_flit;
    assign in_flit[DIR_S] = bus.s_flit;
    assign in_flit[DIR_E] = bus.e_flit;
    assign in_flit[DIR_W] = bus.w_flit;
    assign in_vld         = {bus.w_valid, bus.e_valid, bus.s_valid, bus.n_valid};

    assign bus.n_ready = rdy[DIR_N];
    assign bus.s_ready = rdy[DIR_S];
    assign bus.e_ready = rdy[DIR_E];
    assign bus.w_ready = rdy[DIR_W];

    // A quad goes out whenever the register is free or draining and any lane has data.
    assign load = (!out_valid || bus.out_ready) && !(&empty);

    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_lane
        // Ready is held low during reset even though the count already reads 0.
        assign rdy[d]  = rst_n && (cnt[d] != CNT_W'(DEPTH));
        assign push[d] = in_vld[d] && rdy[d] && !full[d];
        assign pop[d]  = load && !empty[d];

        flit_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[d]),
            .din   (in_flit[d]),
            .pop   (pop[d]),
            .dout  (fifo_dout[d]),
            .full  (full[d]),
            .empty (empty[d]),
            .count (cnt[d])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= {NUM_DIRS{NULL_FLIT}};
            dir_vld   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            for (int d = 0; d < NUM_DIRS; d++)
                out_q[d] <= empty[d] ? NULL_FLIT : fifo_dout[d];
            dir_vld   <= ~empty;
            out_valid <= 1'b1;
        end else if (out_valid && bus.out_ready) begin
            // Flits keep their last value; only the valids drop.
            dir_vld   <= '0;
            out_valid <= 1'b0;
        end
    end

    assign bus.nty       = out_q[DIR_N];
    assign bus.sty       = out_q[DIR_S];
    assign bus.ety       = out_q[DIR_E];
    assign bus.wty       = out_q[DIR_W];
    assign bus.dir_vld   = dir_vld;
    assign bus.out_valid = out_valid;

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (out_valid && !bus.out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign bus.stall_cnt = stall_cnt;
`endif

endmodule
